mul_mdc_input_join: RTL

- Sits between the streamer's three 32-bit source streams (inStream0/1/2) and the multiply dataflow core inside the engine wrapper.
- Buffers each input stream in a small FIFO and joins the three streams beat-by-beat into one aligned output beat for the core.
- Counts beats against a programmed job length and marks the last beat.
- Raises a one-cycle done pulse so the engine wrapper can report job completion to the control unit.

---
 rtl/mul_mdc_input_join.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_mdc_input_join.sv
// Three-stream input join for the multiply dataflow core: per-stream FIFOs, beat alignment,
// job length tracking and done pulse. Optional stall counter under MUL_MDC_INPUT_JOIN_PERF_EN.
//
// state  | meaning
// IDLE   | waiting for start_i; len_i latched on start
// RUN    | accepting inputs up to len beats per stream, emitting joined beats
// DONE   | one-cycle completion pulse, then back to IDLE
module mul_mdc_input_join #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  in0_valid_i,
    input  logic                  in1_valid_i,
    input  logic                  in2_valid_i,
    output logic                  in0_ready_o,
    output logic                  in1_ready_o,
    output logic                  in2_ready_o,
    input  logic [DATA_WIDTH-1:0] in0_data_i,
    input  logic [DATA_WIDTH-1:0] in1_data_i,
    input  logic [DATA_WIDTH-1:0] in2_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data0_o,
    output logic [DATA_WIDTH-1:0] out_data1_o,
    output logic [DATA_WIDTH-1:0] out_data2_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [LEN_WIDTH-1:0]  beat_cnt_o,
    output logic [31:0]           stall_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic [LEN_WIDTH-1:0]  r_acc_cnt [3];
    logic [DATA_WIDTH-1:0] r_mem     [3][FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr  [3];
    logic [AW-1:0]         r_rd_ptr  [3];
    logic [CW-1:0]         r_count   [3];

    logic                  w_sync_rst;
    logic                  w_run;
    logic                  w_start;
    logic [2:0]            w_in_valid;
    logic [2:0]            w_in_ready;
    logic [2:0]            w_push;
    logic [2:0]            w_full;
    logic [2:0]            w_empty;
    logic [DATA_WIDTH-1:0] w_in_data [3];
    logic                  w_out_valid;
    logic                  w_pop;
    logic                  w_last;

    assign w_sync_rst   = !rst_ni || clear_i;
    assign w_run        = (r_state == S_RUN);
    assign w_start      = (r_state == S_IDLE) && start_i;
    assign w_in_valid   = {in2_valid_i, in1_valid_i, in0_valid_i};
    assign w_in_data[0] = in0_data_i;
    assign w_in_data[1] = in1_data_i;
    assign w_in_data[2] = in2_data_i;

    always_comb begin
        w_full     = '0;
        w_empty    = '0;
        w_in_ready = '0;
        w_push     = '0;
        for (int k = 0; k < 3; k++) begin
            w_full[k]     = (r_count[k] == CW'(FIFO_DEPTH));
            w_empty[k]    = (r_count[k] == '0);
            w_in_ready[k] = w_run && !w_full[k] && (r_acc_cnt[k] < r_len);
            w_push[k]     = w_in_valid[k] && w_in_ready[k];
        end
    end

    assign w_out_valid = w_run && (w_empty == 3'b000);
    assign w_pop       = w_out_valid && out_ready_i;
    assign w_last      = w_out_valid && (r_beat_cnt == r_len - LEN_WIDTH'(1));

    // All three FIFOs pop together, so a single pop strobe serves every lane.
    always_ff @(posedge clk_i) begin
        if (w_sync_rst) begin
            for (int k = 0; k < 3; k++) begin
                r_wr_ptr[k]  <= '0;
                r_rd_ptr[k]  <= '0;
                r_count[k]   <= '0;
                r_acc_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_start) begin
                    r_acc_cnt[k] <= '0;
                end else if (w_push[k]) begin
                    r_acc_cnt[k] <= r_acc_cnt[k] + LEN_WIDTH'(1);
                end
                if (w_push[k]) begin
                    r_mem[k][r_wr_ptr[k]] <= w_in_data[k];
                    r_wr_ptr[k]           <= r_wr_ptr[k] + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + AW'(1);
                end
                case ({w_push[k], w_pop})
                    2'b10:   r_count[k] <= r_count[k] + CW'(1);
                    2'b01:   r_count[k] <= r_count[k] - CW'(1);
                    default: r_count[k] <= r_count[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_sync_rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_len      <= len_i;
                        r_beat_cnt <= '0;
                        if (len_i != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_pop) begin
                        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUL_MDC_INPUT_JOIN_PERF_EN
    logic [31:0] r_stall_cnt;

    // Every RUN cycle without an output handshake is a stall; saturates rather than wraps.
    always_ff @(posedge clk_i) begin
        if (w_sync_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt <= '0;
        end else if (w_run && !w_pop && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

    assign in0_ready_o = w_in_ready[0];
    assign in1_ready_o = w_in_ready[1];
    assign in2_ready_o = w_in_ready[2];
    assign out_valid_o = w_out_valid;
    assign out_last_o  = w_last;
    assign out_data0_o = r_mem[0][r_rd_ptr[0]];
    assign out_data1_o = r_mem[1][r_rd_ptr[1]];
    assign out_data2_o = r_mem[2][r_rd_ptr[2]];
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign beat_cnt_o  = r_beat_cnt;

endmodule
